adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `Adder_32` instance between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block latches the granted pair into operand registers that drive the adder and captures the adder's sum a cycle later. It then returns the sum with the requester's ID on a single valid/ready response port. It sits between requesting datapath blocks and the shared 32-bit adder, and instantiates `Adder_32` internally.

---
 rtl/adder_arbiter.sv | 176 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter (with helper module Adder_32)
//  Purpose  : Round-robin arbiter/sequencer that shares one 32-bit adder
//             between NUM_REQ valid/ready requesters and returns each sum,
//             tagged with the requester ID, on one valid/ready response port.
//  Options  : define ADDER_ARB_OVF_EN to add the rsp_ovf carry-out port.
//  Revision : 1.0 - initial release
// ============================================================================

// Shared 32-bit unsigned adder, result modulo 2^32.
module Adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);
    assign s = a + b;
endmodule

module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_sum
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                 rsp_ovf
`endif
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_cur_id;
    logic [ID_W-1:0]    r_rsp_id;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [31:0]        r_rsp_sum;
    logic [31:0]        w_sum;

    logic [31:0]        w_a_arr [NUM_REQ];
    logic [31:0]        w_b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] w_masked;
    logic [NUM_REQ-1:0] w_pick;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_any;
    logic [ID_W-1:0]    w_win_id;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;

    // Unpack the flat operand buses into per-requester words.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
            assign w_a_arr[g] = req_a[32*g +: 32];
            assign w_b_arr[g] = req_b[32*g +: 32];
        end
    endgenerate

    // Round-robin pick: lowest valid index above last_grant, else lowest valid
    // index overall (the wrap), isolated to a one-hot grant.
    always_comb begin
        w_masked = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_masked[k] = req_valid[k] && (k > int'(r_last_grant));
        end
        w_pick   = (|w_masked) ? w_masked : req_valid;
        w_grant  = w_pick & (~w_pick + NUM_REQ'(1));
        w_any    = |req_valid;
        w_win_id = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_win_id = ID_W'(k);
                w_sel_a  = w_a_arr[k];
                w_sel_b  = w_b_arr[k];
            end
        end
    end

    // The adder only ever sees the latched operands.
    Adder_32 u_adder (
        .a (r_op_a),
        .b (r_op_b),
        .s (w_sum)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: accept, one execute cycle, hold until consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_any) w_state_nxt = c_st_exec;
            c_st_exec: w_state_nxt = c_st_resp;
            c_st_resp: if (rsp_ready) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // FSM outputs: grant strobe only while idle, response valid only in RESP.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        case (r_state)
            c_st_idle: req_ready = w_grant;
            c_st_resp: rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: latch operands at accept, capture the sum in EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_cur_id     <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_rsp_id     <= '0;
            r_rsp_sum    <= '0;
        end else begin
            if (r_state == c_st_idle && w_any) begin
                r_op_a       <= w_sel_a;
                r_op_b       <= w_sel_b;
                r_cur_id     <= w_win_id;
                r_last_grant <= w_win_id;
            end
            if (r_state == c_st_exec) begin
                r_rsp_sum <= w_sum;
                r_rsp_id  <= r_cur_id;
            end
        end
    end

    assign rsp_sum = r_rsp_sum;
    assign rsp_id  = r_rsp_id;

`ifdef ADDER_ARB_OVF_EN
    logic r_rsp_ovf;

    // Carry-out: a modulo-2^32 sum smaller than an operand means it wrapped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_ovf <= 1'b0;
        end else if (r_state == c_st_exec) begin
            r_rsp_ovf <= (w_sum < r_op_a);
        end
    end

    assign rsp_ovf = r_rsp_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_arbiter
//  Purpose  : Self-checking bench for adder_arbiter: directed scenarios plus
//             randomized transactions against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_sum;
`ifdef ADDER_ARB_OVF_EN
    logic            rsp_ovf;
`endif

    logic [31:0] a_arr [N];
    logic [31:0] b_arr [N];

    int checks = 0;
    int errors = 0;
    int ref_last;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[32*g +: 32] = a_arr[g];
        assign req_b[32*g +: 32] = b_arr[g];
    end

    adder_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
`ifdef ADDER_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    // Round-robin reference: first valid requester after 'last', wrapping.
    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        for (int k = 0; k < N; k++) begin
            a_arr[k] = '0;
            b_arr[k] = '0;
        end
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        clear_inputs();
        step();
        step();
        rst_n    = 1'b1;
        ref_last = N - 1;
    endtask

    task automatic test_reset();
        reset_dut();
        req_valid = 4'b0100; a_arr[2] = 32'd7; b_arr[2] = 32'd8;
        step();
        req_valid = '0;
        step(); settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd15) begin errors++;
            $display("FAIL pre_reset_rsp: valid=%b sum=%0d, expected valid=1 sum=15", rsp_valid, rsp_sum); end
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_sum !== 32'd0) begin errors++;
            $display("FAIL reset_rsp_sum: got %0d expected 0", rsp_sum); end
        checks++; if (rsp_id !== 2'd0) begin errors++;
            $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
`ifdef ADDER_ARB_OVF_EN
        checks++; if (rsp_ovf !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_ovf: got %b expected 0", rsp_ovf); end
`endif
        req_valid = 4'b1111;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++;
            $display("FAIL reset_priority: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        reset_dut();
        req_valid = 4'b0001; a_arr[0] = 32'd45; b_arr[0] = 32'd27;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++;
            $display("FAIL single_ready: got %b expected 0001", req_ready); end
        step();
        req_valid = '0;
        settle();
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL single_exec: ready=%b valid=%b expected 0000/0", req_ready, rsp_valid); end
        step(); settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd72 || rsp_id !== 2'd0) begin errors++;
            $display("FAIL single_rsp: valid=%b sum=%0d id=%0d expected 1/72/0", rsp_valid, rsp_sum, rsp_id); end
        step(); settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL single_rsp_once: valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int g;
        logic [N-1:0] exp_rdy;
        logic [31:0]  exp_sum;
        reset_dut();
        req_valid = 4'b1111;
        for (int k = 0; k < N; k++) begin
            a_arr[k] = 32'(33 + k);
            b_arr[k] = 32'd142;
        end
        g = 0;
        exp_sum = '0;
        for (int c = 0; c < 15; c++) begin
            settle();
            if (c % 3 == 0) begin
                g = rr_pick(ref_last, req_valid);
                ref_last = g;
                exp_rdy = N'(1) << g;
                exp_sum = a_arr[g] + b_arr[g];
                checks++; if (req_ready !== exp_rdy || rsp_valid !== 1'b0) begin errors++;
                    $display("FAIL rr_grant c=%0d: ready=%b valid=%b expected %b/0", c, req_ready, rsp_valid, exp_rdy); end
            end else if (c % 3 == 1) begin
                checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++;
                    $display("FAIL rr_exec c=%0d: ready=%b valid=%b expected 0000/0", c, req_ready, rsp_valid); end
            end else begin
                checks++; if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum || rsp_id !== IW'(g) || req_ready !== 4'b0000) begin errors++;
                    $display("FAIL rr_rsp c=%0d: valid=%b sum=%0d id=%0d ready=%b expected 1/%0d/%0d/0000",
                             c, rsp_valid, rsp_sum, rsp_id, req_ready, exp_sum, g); end
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        reset_dut();
        rsp_ready = 1'b0;
        req_valid = 4'b0010; a_arr[1] = 32'd0; b_arr[1] = 32'd0;
        settle();
        checks++; if (req_ready !== 4'b0010) begin errors++;
            $display("FAIL bp_accept: got %b expected 0010", req_ready); end
        step();
        req_valid = 4'b0100; a_arr[2] = 32'd1000; b_arr[2] = 32'd2345;
        settle();
        checks++; if (req_ready !== 4'b0000) begin errors++;
            $display("FAIL bp_exec_ready: got %b expected 0000", req_ready); end
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd0 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin errors++;
                $display("FAIL bp_hold i=%0d: valid=%b sum=%0d id=%0d ready=%b expected 1/0/1/0000",
                         i, rsp_valid, rsp_sum, rsp_id, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++;
            $display("FAIL bp_release: valid=%b id=%0d expected 1/1", rsp_valid, rsp_id); end
        step(); settle();
        checks++; if (req_ready !== 4'b0100) begin errors++;
            $display("FAIL bp_next_grant: got %b expected 0100", req_ready); end
        step();
        req_valid = '0;
        step(); settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd3345 || rsp_id !== 2'd2) begin errors++;
            $display("FAIL bp_second_rsp: valid=%b sum=%0d id=%0d expected 1/3345/2", rsp_valid, rsp_sum, rsp_id); end
        step();
    endtask

    task automatic test_wrap();
        reset_dut();
        req_valid = 4'b1000; a_arr[3] = 32'hFFFF_FFFF; b_arr[3] = 32'd1;
        settle();
        checks++; if (req_ready !== 4'b1000) begin errors++;
            $display("FAIL wrap_accept: got %b expected 1000", req_ready); end
        step();
        req_valid = '0;
        step(); settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd0 || rsp_id !== 2'd3) begin errors++;
            $display("FAIL wrap_rsp: valid=%b sum=%0d id=%0d expected 1/0/3", rsp_valid, rsp_sum, rsp_id); end
`ifdef ADDER_ARB_OVF_EN
        checks++; if (rsp_ovf !== 1'b1) begin errors++;
            $display("FAIL wrap_ovf: got %b expected 1", rsp_ovf); end
`endif
        step();
    endtask

    task automatic test_reset_in_exec();
        reset_dut();
        req_valid = 4'b0001; a_arr[0] = 32'd5; b_arr[0] = 32'd6;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++;
            $display("FAIL rexec_accept: got %b expected 0001", req_ready); end
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        settle();
        checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0) begin errors++;
            $display("FAIL rexec_discard: valid=%b sum=%0d expected 0/0", rsp_valid, rsp_sum); end
        step(); settle();
        checks++; if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rexec_no_rsp: valid=%b expected 0", rsp_valid); end
        req_valid = 4'b1000; a_arr[3] = 32'd20; b_arr[3] = 32'd22;
        settle();
        checks++; if (req_ready !== 4'b1000) begin errors++;
            $display("FAIL rexec_req3: got %b expected 1000", req_ready); end
        step();
        req_valid = '0;
        step(); settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd42 || rsp_id !== 2'd3) begin errors++;
            $display("FAIL rexec_rsp3: valid=%b sum=%0d id=%0d expected 1/42/3", rsp_valid, rsp_sum, rsp_id); end
        step();
    endtask

    task automatic test_operand_change();
        reset_dut();
        req_valid = 4'b0010; a_arr[1] = 32'd10; b_arr[1] = 32'd5;
        settle();
        checks++; if (req_ready !== 4'b0010) begin errors++;
            $display("FAIL opchg_accept: got %b expected 0010", req_ready); end
        step();
        req_valid = '0;
        a_arr[1]  = 32'd99;
        step(); settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd15 || rsp_id !== 2'd1) begin errors++;
            $display("FAIL opchg_rsp: valid=%b sum=%0d id=%0d expected 1/15/1", rsp_valid, rsp_sum, rsp_id); end
        step();
    endtask

    task automatic randomize_operands();
        for (int k = 0; k < N; k++) begin
            a_arr[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b_arr[k] = $urandom;
        end
    endtask

    task automatic test_random();
        int          k;
        int          stalls;
        logic [N-1:0] exp_rdy;
        logic [32:0] wide;
        logic [31:0] exp_sum;
        logic        exp_ovf;
        reset_dut();
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                randomize_operands();
                settle();
                checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++;
                    $display("FAIL rnd_idle t=%0d: ready=%b valid=%b expected 0000/0", t, req_ready, rsp_valid); end
                step();
            end
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            randomize_operands();
            settle();
            k = rr_pick(ref_last, req_valid);
            ref_last = k;
            exp_rdy  = N'(1) << k;
            wide     = {1'b0, a_arr[k]} + {1'b0, b_arr[k]};
            exp_sum  = wide[31:0];
            exp_ovf  = wide[32];
            checks++; if (req_ready !== exp_rdy) begin errors++;
                $display("FAIL rnd_grant t=%0d: ready=%b expected %b (valid=%b)", t, req_ready, exp_rdy, req_valid); end
            step();
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            randomize_operands();
            settle();
            checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++;
                $display("FAIL rnd_exec t=%0d: ready=%b valid=%b expected 0000/0", t, req_ready, rsp_valid); end
            step();
            stalls = $urandom_range(0, 3);
            for (int s = 0; s <= stalls; s++) begin
                rsp_ready = (s == stalls);
                settle();
                checks++; if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum || rsp_id !== IW'(k) || req_ready !== 4'b0000) begin errors++;
                    $display("FAIL rnd_rsp t=%0d s=%0d: valid=%b sum=%h id=%0d ready=%b expected 1/%h/%0d/0000",
                             t, s, rsp_valid, rsp_sum, rsp_id, req_ready, exp_sum, k); end
`ifdef ADDER_ARB_OVF_EN
                checks++; if (rsp_ovf !== exp_ovf) begin errors++;
                    $display("FAIL rnd_ovf t=%0d: got %b expected %b", t, rsp_ovf, exp_ovf); end
`else
                if (exp_ovf === 1'bx) $display("note: unexpected X carry");
`endif
                step();
            end
            req_valid = '0;
        end
        rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_in_exec();
        test_operand_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
